// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with issue/writeback busy scoreboard.
// Optional same-cycle write-to-read bypass is built when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NRD*ADDR_W-1:0]  i_rs_addr,
    output logic [NRD*DATA_W-1:0]  o_rs_data,
    output logic [NRD-1:0]         o_rs_busy,
    input  logic                   i_wa_en,
    input  logic [ADDR_W-1:0]      i_wa_addr,
    input  logic [DATA_W-1:0]      i_wa_data,
    input  logic                   i_wb_en,
    input  logic [ADDR_W-1:0]      i_wb_addr,
    input  logic [DATA_W-1:0]      i_wb_data,
    input  logic                   i_iss_en,
    input  logic [ADDR_W-1:0]      i_iss_addr,
    output logic [2**ADDR_W-1:0]   o_busy_vec,
    output logic                   o_conflict
);
    localparam int NREG = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic              conflict_q, conflict_d;
    logic              wa_ok, wb_ok, iss_ok;

    // Register 0 is hardwired: any access to it is ignored; nothing acts while in reset.
    assign wa_ok  = i_rst && i_wa_en && (i_wa_addr != '0);
    assign wb_ok  = i_rst && i_wb_en && (i_wb_addr != '0);
    assign iss_ok = i_rst && i_iss_en && (i_iss_addr != '0);

    // Next register contents: port B is applied last so it wins a same-address collision.
    always_comb begin
        for (int n = 0; n < NREG; n++) begin
            regs_d[n] = regs_q[n];
            if (wa_ok && i_wa_addr == ADDR_W'(n)) regs_d[n] = i_wa_data;
            if (wb_ok && i_wb_addr == ADDR_W'(n)) regs_d[n] = i_wb_data;
        end
    end

    // Next scoreboard: issue sets (and beats a concurrent writeback), writeback clears.
    always_comb begin
        for (int n = 0; n < NREG; n++)
            busy_d[n] = (iss_ok && i_iss_addr == ADDR_W'(n)) ? 1'b1 :
                        ((wa_ok && i_wa_addr == ADDR_W'(n)) || (wb_ok && i_wb_addr == ADDR_W'(n))) ? 1'b0 :
                        busy_q[n];
    end

    assign conflict_d = wa_ok && wb_ok && (i_wa_addr == i_wb_addr);

    // State registers with asynchronous active-low clear.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            conflict_q <= conflict_d;
        end
    end

    assign o_busy_vec = busy_q;
    assign o_conflict = conflict_q;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = i_rs_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_SB_BYPASS_EN
        logic hit_a, hit_b;
        assign hit_a = wa_ok && (i_wa_addr == a);
        assign hit_b = wb_ok && (i_wb_addr == a);
        assign o_rs_data[k*DATA_W +: DATA_W] = hit_b ? i_wb_data : hit_a ? i_wa_data : regs_q[a];
        assign o_rs_busy[k] = (hit_a || hit_b) ? (iss_ok && i_iss_addr == a) : busy_q[a];
`else
        assign o_rs_data[k*DATA_W +: DATA_W] = regs_q[a];
        assign o_rs_busy[k] = busy_q[a];
`endif
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;
    localparam int DW = 32, AW = 5, NR = 2, NREG = 32;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0, rst;
    logic [NR*AW-1:0] rs_addr;
    logic [NR*DW-1:0] rs_data;
    logic [NR-1:0]    rs_busy;
    logic            wa_en, wb_en, iss_en;
    logic [AW-1:0]   wa_addr, wb_addr, iss_addr;
    logic [DW-1:0]   wa_data, wb_data;
    logic [NREG-1:0] busy_vec;
    logic            conflict;

    int n_chk = 0, n_fail = 0;
    bit chk_on = 1'b0;

    logic [DW-1:0]   m_reg [NREG];
    logic [NREG-1:0] m_busy;
    logic            m_conf;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .i_clk(clk), .i_rst(rst), .i_rs_addr(rs_addr), .o_rs_data(rs_data), .o_rs_busy(rs_busy),
        .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .i_iss_en(iss_en), .i_iss_addr(iss_addr), .o_busy_vec(busy_vec), .o_conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an array of register values and a bit set of pending destinations.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) m_reg[i] <= '0;
            m_busy <= '0;
            m_conf <= 1'b0;
        end else begin
            if (wa_en && wa_addr != 0) begin m_reg[wa_addr] <= wa_data; m_busy[wa_addr] <= 1'b0; end
            if (wb_en && wb_addr != 0) begin m_reg[wb_addr] <= wb_data; m_busy[wb_addr] <= 1'b0; end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] <= 1'b1;
            m_conf <= wa_en && wb_en && wa_addr == wb_addr && wa_addr != 0;
        end
    end

    // Compare every output against the model once per cycle, mid-period.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NR; k++) begin
                logic [AW-1:0] a;
                logic ha, hb;
                logic [DW-1:0] ed;
                logic eb;
                a  = rs_addr[k*AW +: AW];
                ha = BYP && rst && wa_en && wa_addr == a && a != 0;
                hb = BYP && rst && wb_en && wb_addr == a && a != 0;
                ed = !rst ? '0 : hb ? wb_data : ha ? wa_data : m_reg[a];
                eb = !rst ? 1'b0 : (ha || hb) ? (iss_en && iss_addr == a) : m_busy[a];
                chk($sformatf("rd_data%0d", k), 64'(rs_data[k*DW +: DW]), 64'(ed));
                chk($sformatf("rd_busy%0d", k), 64'(rs_busy[k]), 64'(eb));
            end
            chk("busy_vec", 64'(busy_vec), 64'(m_busy));
            chk("conflict", 64'(conflict), 64'(m_conf));
        end
    end

    task automatic idle();
        wa_en = 0; wb_en = 0; iss_en = 0;
    endtask

    task automatic go();
        @(posedge clk); #1;
        idle();
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rs_data[k*DW +: DW];
    endfunction

    initial begin
        rst = 0; idle(); rs_addr = '0;
        wa_addr = 0; wb_addr = 0; iss_addr = 0; wa_data = 0; wb_data = 0;
        // A write presented while reset is held must be discarded.
        wa_en = 1; wa_addr = 6; wa_data = 32'h77;
        repeat (2) @(posedge clk);
        #1 idle(); rst = 1; chk_on = 1'b1;
        #1 rs_addr[AW-1:0] = 6; #1;
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_discard_x6", 64'(rd(0)), 64'h0);
        // Basic write / read and the hardwired zero register.
        wa_en = 1; wa_addr = 5; wa_data = 32'h1234_5678; rs_addr[AW-1:0] = 5;
        go();
        chk("x5_read", 64'(rd(0)), 64'h1234_5678);
        wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF; rs_addr[AW-1:0] = 0;
        go();
        chk("x0_read", 64'(rd(0)), 64'h0);
        // Dual write to one address: port B lands, conflict pulses once.
        wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA_AAAA;
        wb_en = 1; wb_addr = 7; wb_data = 32'h5555_5555; rs_addr[AW-1:0] = 7;
        go();
        chk("conflict_pulse", 64'(conflict), 64'h1);
        chk("x7_portb", 64'(rd(0)), 64'h5555_5555);
        go();
        chk("conflict_drop", 64'(conflict), 64'h0);
        // Scoreboard set, clear, and issue winning over a writeback.
        iss_en = 1; iss_addr = 3; rs_addr[AW-1:0] = 3;
        go();
        chk("busy3_set", 64'(busy_vec[3]), 64'h1);
        chk("rs_busy3", 64'(rs_busy[0]), 64'h1);
        wb_en = 1; wb_addr = 3; wb_data = 32'h33;
        go();
        chk("busy3_clr", 64'(busy_vec[3]), 64'h0);
        iss_en = 1; iss_addr = 3; wa_en = 1; wa_addr = 3; wa_data = 32'h34;
        go();
        chk("busy3_issue_wins", 64'(busy_vec[3]), 64'h1);
        // Same-cycle read of a write in flight.
        wa_en = 1; wa_addr = 9; wa_data = 32'hDEAD_BEEF; rs_addr[2*AW-1:AW] = 9; #1;
        chk("x9_same_cycle", 64'(rd(1)), BYP ? 64'hDEAD_BEEF : 64'h0);
        chk("x9_same_busy", 64'(rs_busy[1]), 64'h0);
        go();
        chk("x9_next", 64'(rd(1)), 64'hDEAD_BEEF);
        // Mid-cycle asynchronous reset clears state before the next edge.
        wa_en = 1; wa_addr = 4; wa_data = 32'h1; rs_addr[AW-1:0] = 4;
        go();
        iss_en = 1; iss_addr = 4;
        go();
        chk("x4_pre_reset", 64'(rd(0)), 64'h1);
        chk("busy4_pre_reset", 64'(busy_vec[4]), 64'h1);
        rst = 0; #1;
        chk("x4_async_rst", 64'(rd(0)), 64'h0);
        chk("busy_async_rst", 64'(busy_vec), 64'h0);
        @(posedge clk); #1 rst = 1; #1;
        // Randomized traffic, biased to low addresses to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!rst) rst = 1;
            wa_en = 1'($urandom); wb_en = 1'($urandom); iss_en = ($urandom_range(0, 2) == 0);
            wa_addr = AW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
            wb_addr = AW'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7));
            iss_addr = AW'($urandom_range(0, 7));
            wa_data = $urandom; wb_data = $urandom;
            rs_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            if ($urandom_range(0, 299) == 0) begin #2 rst = 0; end
        end
        @(posedge clk); #1 idle(); rst = 1;
        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
